// File: rtl/speaker_i2s_ctrl_if.sv
// ---------------------------------------------------------------------------
// speaker_i2s_ctrl_if : sample inputs and I2S pin outputs of speaker_i2s_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface speaker_i2s_ctrl_if #(
   parameter int SAMPLE_W = 16
);
   logic [SAMPLE_W-1:0] audio_in_l;
   logic [SAMPLE_W-1:0] audio_in_r;
   logic                mute;
   logic                sample_tick;
   logic                audio_mclk;
   logic                audio_sck;
   logic                audio_lrck;
   logic                audio_sdin;

   modport master (
      output audio_in_l, audio_in_r, mute,
      input  sample_tick, audio_mclk, audio_sck, audio_lrck, audio_sdin
   );

   modport slave (
      input  audio_in_l, audio_in_r, mute,
      output sample_tick, audio_mclk, audio_sck, audio_lrck, audio_sdin
   );
endinterface

`default_nettype wire

// File: rtl/speaker_i2s_ctrl.sv
// ---------------------------------------------------------------------------
// speaker_i2s_ctrl : latches one stereo sample per 512-clk frame and shifts it
//                    out in I2S format with MCLK/SCK/LRCK from a free counter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module speaker_i2s_ctrl #(
   parameter int SAMPLE_W = 16,
   parameter int CNT_W    = 9
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   speaker_i2s_ctrl_if.slave  bus
);

   logic [CNT_W-1:0]    r_cnt;
   logic [SAMPLE_W-1:0] r_hold_l;
   logic [SAMPLE_W-1:0] r_hold_r;
   logic                r_lsb_r;
   logic                r_sdin;

   logic                w_tick;
   logic                w_bit_edge;
   logic [4:0]          w_pos_nxt;
   logic [3:0]          w_slot;
   logic                w_half;
   logic [3:0]          w_idx;
   logic                w_lsb_nxt;
   logic                w_bit_nxt;

   assign w_tick     = (r_cnt == '1);
   assign w_bit_edge = (r_cnt[3:0] == 4'hF);

   // Slot/half of the bit period that starts after this edge; sdin is loaded one edge ahead.
   assign w_pos_nxt  = r_cnt[8:4] + 5'd1;
   assign w_slot     = w_pos_nxt[3:0];
   assign w_half     = w_pos_nxt[4];
   assign w_idx      = 4'd0 - w_slot;

   // The right LSB sent at frame wrap is the value being retired on this same edge.
   assign w_lsb_nxt  = w_tick ? r_hold_r[0] : r_lsb_r;

   always_comb begin
      w_bit_nxt = 1'b0;
      if (w_slot == 4'd0) begin
         w_bit_nxt = w_half ? r_hold_l[0] : w_lsb_nxt;
      end else begin
         w_bit_nxt = w_half ? r_hold_r[w_idx] : r_hold_l[w_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_hold_l <= '0;
         r_hold_r <= '0;
         r_lsb_r  <= 1'b0;
         r_sdin   <= 1'b0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_tick) begin
            r_lsb_r  <= w_lsb_nxt;
            r_hold_l <= bus.mute ? '0 : bus.audio_in_l;
            r_hold_r <= bus.mute ? '0 : bus.audio_in_r;
         end
         if (w_bit_edge) begin
            r_sdin <= w_bit_nxt;
         end
      end
   end

   assign bus.sample_tick = w_tick;
   assign bus.audio_mclk  = r_cnt[1];
   assign bus.audio_sck   = r_cnt[3];
   assign bus.audio_lrck  = r_cnt[CNT_W-1];
   assign bus.audio_sdin  = r_sdin;

endmodule

`default_nettype wire

// File: tb/tb_speaker_i2s_ctrl.sv
// ---------------------------------------------------------------------------
// tb_speaker_i2s_ctrl : self-checking bench for speaker_i2s_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_speaker_i2s_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   speaker_i2s_ctrl_if #(.SAMPLE_W(16)) bus ();

   speaker_i2s_ctrl #(.SAMPLE_W(16), .CNT_W(9)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame position plus the 32-bit serial word of the current frame,
   // built as {previous right LSB, left word, right word without its LSB}.
   int          m_cnt;
   logic [31:0] m_stream;
   logic        m_prev_r0;
   logic [15:0] m_l;
   logic [15:0] m_r;
   assign m_l = bus.mute ? 16'h0000 : bus.audio_in_l;
   assign m_r = bus.mute ? 16'h0000 : bus.audio_in_r;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt     <= 0;
         m_stream  <= '0;
         m_prev_r0 <= 1'b0;
      end else begin
         m_cnt <= (m_cnt + 1) % 512;
         if (m_cnt == 511) begin
            m_stream  <= {m_prev_r0, m_l, m_r[15:1]};
            m_prev_r0 <= m_r[0];
         end
      end
   end

   // Cycle monitor: compares every output with the model and captures sdin mid-slot.
   logic [31:0] cap;
   logic [31:0] last_cap;
   logic        prev_valid;
   logic        prev_sdin;
   logic        prev_sck;

   initial begin
      cap        = '0;
      last_cap   = '0;
      prev_valid = 1'b0;
      prev_sdin  = 1'b0;
      prev_sck   = 1'b0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("outputs_in_reset",
             {27'd0, bus.audio_mclk, bus.audio_sck, bus.audio_lrck, bus.audio_sdin, bus.sample_tick},
             32'd0);
         prev_valid = 1'b0;
         cap        = '0;
      end else begin
         chk("mclk", {31'd0, bus.audio_mclk}, {31'd0, (m_cnt % 4) >= 2});
         chk("sck",  {31'd0, bus.audio_sck},  {31'd0, (m_cnt % 16) >= 8});
         chk("lrck", {31'd0, bus.audio_lrck}, {31'd0, m_cnt >= 256});
         chk("sample_tick", {31'd0, bus.sample_tick}, {31'd0, m_cnt == 511});
         chk("sdin", {31'd0, bus.audio_sdin}, {31'd0, m_stream[31 - (m_cnt / 16)]});
         if (prev_valid && (bus.audio_sdin !== prev_sdin))
            chk("sdin_on_sck_fall", {30'd0, prev_sck, bus.audio_sck}, 32'd2);
         prev_valid = 1'b1;
         prev_sdin  = bus.audio_sdin;
         prev_sck   = bus.audio_sck;
         if ((m_cnt % 16) == 8) cap = {cap[30:0], bus.audio_sdin};
         if (m_cnt == 511) last_cap = cap;
      end
   end

   task automatic wait_tick();
      int n;
      n = 0;
      @(negedge clk);
      while (bus.sample_tick !== 1'b1 && n < 1100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1100) chk("tick_timeout", 32'd1, 32'd0);
   endtask

   // Ends a frame and runs into slot 0 of the next, so last_cap plus cap[0] hold both words.
   task automatic frame_done();
      wait_tick();
      repeat (12) @(negedge clk);
   endtask

   task automatic wait_cnt(input int target);
      int n;
      n = 0;
      while (m_cnt != target && n < 1100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1100) chk("cnt_timeout", 32'd1, 32'd0);
   endtask

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic        mute;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{16'hA5A5, 16'h0001, 1'b0, 16'hA5A5, 16'h0001};
      vecs[1] = '{16'h1234, 16'hABCD, 1'b0, 16'h1234, 16'hABCD};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFF};
      vecs[4] = '{16'h8000, 16'h7FFE, 1'b0, 16'h8000, 16'h7FFE};
      vecs[5] = '{16'h0F0F, 16'hC3C3, 1'b1, 16'h0000, 16'h0000};

      checks         = 0;
      errors         = 0;
      rst_n          = 1'b0;
      bus.audio_in_l = 16'h1357;
      bus.audio_in_r = 16'h2469;
      bus.mute       = 1'b0;

      // Reset and first frame: data present before release must not appear in frame 0.
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b1;
      frame_done();
      chk("first_frame_zero", last_cap, 32'd0);

      // Table vectors: apply mid-frame, latched at end of this frame, sent in the next.
      for (int i = 0; i < 6; i++) begin
         bus.audio_in_l = vecs[i].l;
         bus.audio_in_r = vecs[i].r;
         bus.mute       = vecs[i].mute;
         frame_done();
         frame_done();
         chk($sformatf("vec%0d_left", i), {16'd0, last_cap[30:15]}, {16'd0, vecs[i].exp_l});
         chk($sformatf("vec%0d_right", i), {16'd0, last_cap[14:0], cap[0]}, {16'd0, vecs[i].exp_r});
         if (i == 0) chk("right_lsb_in_next_slot0", {31'd0, cap[0]}, 32'd1);
      end
      bus.mute = 1'b0;

      // Mid-frame change of the left sample must not disturb the frame in flight.
      bus.audio_in_l = 16'h7FFF;
      bus.audio_in_r = 16'h0000;
      frame_done();
      wait_cnt(100);
      bus.audio_in_l = 16'h8000;
      frame_done();
      chk("midframe_old_left", {16'd0, last_cap[30:15]}, 32'h7FFF);
      frame_done();
      chk("midframe_new_left", {16'd0, last_cap[30:15]}, 32'h8000);

      // Mute asserted mid-frame only bites at the next latch.
      bus.audio_in_l = 16'hFFFF;
      bus.audio_in_r = 16'hFFFF;
      frame_done();
      wait_cnt(200);
      bus.mute = 1'b1;
      frame_done();
      chk("mute_late_left", {16'd0, last_cap[30:15]}, 32'hFFFF);
      frame_done();
      chk("mute_left", {16'd0, last_cap[30:15]}, 32'h0000);
      chk("mute_right", {16'd0, last_cap[14:0], cap[0]}, 32'h0000);
      bus.mute = 1'b0;

      // Randomized traffic: inputs change at random points, monitor compares every cycle.
      for (int f = 0; f < 16; f++) begin
         repeat ($urandom_range(1, 200)) @(negedge clk);
         bus.audio_in_l = 16'($urandom);
         bus.audio_in_r = 16'($urandom);
         bus.mute       = ($urandom_range(0, 3) == 0);
         wait_tick();
         @(negedge clk);
         bus.audio_in_l = 16'($urandom);
      end
      bus.mute = 1'b0;

      // Reset in the middle of a frame.
      bus.audio_in_l = 16'hDEAD;
      bus.audio_in_r = 16'hBEEF;
      frame_done();
      wait_cnt(300);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          {27'd0, bus.audio_mclk, bus.audio_sck, bus.audio_lrck, bus.audio_sdin, bus.sample_tick},
          32'd0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b1;
      frame_done();
      chk("frame_after_reset_zero", last_cap, 32'd0);
      frame_done();
      chk("post_reset_left", {16'd0, last_cap[30:15]}, 32'hDEAD);
      chk("post_reset_right", {16'd0, last_cap[14:0], cap[0]}, 32'hBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
